// File: rtl/tff_state_mon_pkg.sv
// Shared types and the toggle-equation predictor for the T-flip-flop counter monitor.
package tff_state_mon_pkg;

  typedef logic [3:0] state_t;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FAULT} mon_state_e;

  // Bit order {A,B,C,D}: TA=C&D, TB=D, TC=1, TD=0.
  function automatic state_t next_state(state_t s);
    logic ta;
    logic tb;
    ta = s[1] & s[0];
    tb = s[0];
    return {s[3] ^ ta, s[2] ^ tb, ~s[1], s[0]};
  endfunction

endpackage

// File: rtl/tff_period_meter.sv
// Measures the revisit period of REF_STATE over consecutive enabled samples.
module tff_period_meter
  import tff_state_mon_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 8,
  parameter state_t      REF_STATE = 4'b0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample,
  input  state_t              state_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  logic [PERIOD_W-1:0] pc_q, pc_d, pc_inc;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                armed_q, armed_d;
  logic                pv_q, pv_d;

  assign pc_inc = (pc_q == '1) ? pc_q : pc_q + PERIOD_W'(1);

  always_comb begin
    pc_d     = pc_q;
    armed_d  = armed_q;
    period_d = period_q;
    pv_d     = 1'b0;
    if (clear) begin
      pc_d    = '0;
      armed_d = 1'b0;
    end else if (sample) begin
      if (state_in == REF_STATE) begin
        // First visit only arms; later visits report samples since the previous one.
        if (armed_q) begin
          period_d = pc_inc;
          pv_d     = 1'b1;
        end
        armed_d = 1'b1;
        pc_d    = '0;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      armed_q  <= 1'b0;
      period_q <= '0;
      pv_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      armed_q  <= armed_d;
      period_q <= period_d;
      pv_q     <= pv_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;

endmodule

// File: rtl/tff_state_monitor.sv
// Checks the 4-bit T-FF counter for illegal transitions and measures a reference-state period.
// Optional sample history built when TFF_STATE_MON_HISTORY_EN is defined.
module tff_state_monitor
  import tff_state_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned ERR_LIMIT = 1,
  parameter int unsigned PERIOD_W  = 8,
  parameter state_t      REF_STATE = 4'b0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [3:0]          state_in,
  input  logic                fault_clr,
  output logic                mismatch,
  output logic                fault,
  output logic [CNT_W-1:0]    err_count,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [15:0]         hist
);

  mon_state_e       st_q, st_d;
  state_t           prev_q, prev_d;
  logic             mismatch_q, mismatch_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] err_q, err_d, err_inc;
  logic             bad;
  logic             sample;
  logic             pm_clear;

  assign err_inc  = (err_q == '1) ? err_q : err_q + CNT_W'(1);
  assign sample   = ((st_q == PRIME) || (st_q == RUN)) && en;
  assign pm_clear = (st_q == IDLE) || (st_q == FAULT);

  always_comb begin
    st_d       = st_q;
    prev_d     = prev_q;
    mismatch_d = 1'b0;
    fault_d    = fault_q;
    err_d      = err_q;
    bad        = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (en) st_d = PRIME;
      end
      PRIME: begin
        if (en) begin
          prev_d = state_in;
          st_d   = RUN;
        end else begin
          st_d = IDLE;
        end
      end
      RUN: begin
        // Clear takes priority over a coincident bad transition.
        if (fault_clr) begin
          st_d    = PRIME;
          fault_d = 1'b0;
          err_d   = '0;
        end else if (en) begin
          bad    = (state_in != next_state(prev_q));
          prev_d = state_in;
          if (bad) begin
            mismatch_d = 1'b1;
            err_d      = err_inc;
            if ((ERR_LIMIT != 0) && (32'(err_inc) == ERR_LIMIT)) begin
              st_d    = FAULT;
              fault_d = 1'b1;
            end
          end
        end else begin
          st_d = IDLE;
        end
      end
      FAULT: begin
        if (fault_clr) begin
          st_d    = PRIME;
          fault_d = 1'b0;
          err_d   = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q       <= IDLE;
      prev_q     <= '0;
      mismatch_q <= 1'b0;
      fault_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      st_q       <= st_d;
      prev_q     <= prev_d;
      mismatch_q <= mismatch_d;
      fault_q    <= fault_d;
      err_q      <= err_d;
    end
  end

  assign mismatch  = mismatch_q;
  assign fault     = fault_q;
  assign err_count = err_q;

  tff_period_meter #(
    .PERIOD_W  (PERIOD_W),
    .REF_STATE (REF_STATE)
  ) u_period_meter (
    .clock        (clock),
    .reset        (reset),
    .clear        (pm_clear),
    .sample       (sample),
    .state_in     (state_in),
    .period       (period),
    .period_valid (period_valid)
  );

`ifdef TFF_STATE_MON_HISTORY_EN
  logic [15:0] hist_q;

  // FAULT is outside the sampling states, so history freezes there by construction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else if (sample) begin
      hist_q <= {hist_q[11:0], state_in};
    end
  end

  assign hist = hist_q;
`else
  assign hist = '0;
`endif

endmodule

// File: tb/tb_tff_state_monitor.sv
// Self-checking bench: directed vector table, corner sequences and randomized model comparison.
module tb_tff_state_monitor;

  logic       clock;
  logic       reset;
  logic       en;
  logic [3:0] state_in;
  logic       fault_clr;

  logic       mis0, mis1, mis2;
  logic       flt0, flt1, flt2;
  logic [3:0] err0, err1;
  logic [1:0] err2;
  logic [7:0] per0, per1, per2;
  logic       pv0, pv1, pv2;
  logic [15:0] hist0, hist1, hist2;

  int n_chk = 0;
  int n_err = 0;

  tff_state_monitor u0 (
    .clock(clock), .reset(reset), .en(en), .state_in(state_in), .fault_clr(fault_clr),
    .mismatch(mis0), .fault(flt0), .err_count(err0), .period(per0),
    .period_valid(pv0), .hist(hist0)
  );

  tff_state_monitor #(.ERR_LIMIT(3)) u1 (
    .clock(clock), .reset(reset), .en(en), .state_in(state_in), .fault_clr(fault_clr),
    .mismatch(mis1), .fault(flt1), .err_count(err1), .period(per1),
    .period_valid(pv1), .hist(hist1)
  );

  tff_state_monitor #(.CNT_W(2), .ERR_LIMIT(0)) u2 (
    .clock(clock), .reset(reset), .en(en), .state_in(state_in), .fault_clr(fault_clr),
    .mismatch(mis2), .fault(flt2), .err_count(err2), .period(per2),
    .period_valid(pv2), .hist(hist2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: flags describe whether checking is active, whether a previous
  // sample is held, and whether the monitor is latched in fault.
  typedef struct {
    bit active;
    bit primed;
    bit faulted;
    int prev;
    int errs;
    int pc;
    bit armed;
    int period;
    int hist;
    bit mis;
    bit pv;
  } mdl_t;

  mdl_t m[3];
  int   lim[3]  = '{1, 3, 0};
  int   cmax[3] = '{15, 15, 3};

  function automatic int legal(int s);
    int r;
    r = s ^ 2;
    if ((s & 1) != 0) r = r ^ 4;
    if ((s & 3) == 3) r = r ^ 8;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].active = 0; m[i].primed = 0; m[i].faulted = 0; m[i].prev = 0;
      m[i].errs = 0; m[i].pc = 0; m[i].armed = 0; m[i].period = 0;
      m[i].hist = 0; m[i].mis = 0; m[i].pv = 0;
    end
  endtask

  task automatic period_sample(input int i, input int s);
    if (s == 0) begin
      if (m[i].armed) begin
        m[i].period = (m[i].pc + 1 > 255) ? 255 : m[i].pc + 1;
        m[i].pv = 1;
      end
      m[i].armed = 1;
      m[i].pc = 0;
    end else begin
      m[i].pc = (m[i].pc < 255) ? m[i].pc + 1 : 255;
    end
  endtask

  task automatic model_step(input bit e, input int s, input bit c);
    for (int i = 0; i < 3; i++) begin
      m[i].mis = 0;
      m[i].pv  = 0;
      if (m[i].faulted || !m[i].active) begin
        m[i].pc = 0;
        m[i].armed = 0;
        if (m[i].faulted) begin
          if (c) begin m[i].faulted = 0; m[i].errs = 0; m[i].primed = 0; end
        end else if (e) begin
          m[i].active = 1;
          m[i].primed = 0;
        end
      end else begin
        if (e) begin
          period_sample(i, s);
          m[i].hist = ((m[i].hist << 4) | s) & 16'hffff;
        end
        if (!m[i].primed) begin
          if (e) begin m[i].prev = s; m[i].primed = 1; end
          else m[i].active = 0;
        end else if (c) begin
          m[i].errs = 0;
          m[i].primed = 0;
        end else if (e) begin
          if (s != legal(m[i].prev)) begin
            m[i].mis = 1;
            m[i].errs = (m[i].errs + 1 > cmax[i]) ? cmax[i] : m[i].errs + 1;
            if (lim[i] != 0 && m[i].errs == lim[i]) m[i].faulted = 1;
          end
          m[i].prev = s;
        end else begin
          m[i].active = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int am, af, ae, ap, av, ah, eh;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin am = mis0; af = flt0; ae = err0; ap = per0; av = pv0; ah = hist0; end
        1: begin am = mis1; af = flt1; ae = err1; ap = per1; av = pv1; ah = hist1; end
        default: begin am = mis2; af = flt2; ae = err2; ap = per2; av = pv2; ah = hist2; end
      endcase
`ifdef TFF_STATE_MON_HISTORY_EN
      eh = m[i].hist;
`else
      eh = 0;
`endif
      chk($sformatf("u%0d.mismatch", i), am, m[i].mis);
      chk($sformatf("u%0d.fault", i), af, m[i].faulted);
      chk($sformatf("u%0d.err_count", i), ae, m[i].errs);
      chk($sformatf("u%0d.period", i), ap, m[i].period);
      chk($sformatf("u%0d.period_valid", i), av, m[i].pv);
      chk($sformatf("u%0d.hist", i), ah, eh);
    end
  endtask

  task automatic step(input bit e, input logic [3:0] s, input bit c);
    en = e;
    state_in = s;
    fault_clr = c;
    @(posedge clock);
    model_step(e, int'(s), c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    en = 1'b0;
    state_in = '0;
    fault_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check_all();
  endtask

  typedef struct {
    bit         en;
    logic [3:0] s;
    bit         clr;
    bit         mis;
    bit         pv;
    int         per;
    bit         flt;
    int         err;
    bit         mis1;
    int         err1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit e, input logic [3:0] s, input bit c, input bit mi, input bit pv,
                     input int pe, input bit f, input int er, input bit mi1, input int er1);
    vec_t v;
    v.en = e; v.s = s; v.clr = c; v.mis = mi; v.pv = pv; v.per = pe;
    v.flt = f; v.err = er; v.mis1 = mi1; v.err1 = er1;
    tbl.push_back(v);
  endtask

  initial begin
    int pulses;
    int cnt;
    reset = 1'b0;
    en = 1'b0;
    state_in = '0;
    fault_clr = 1'b0;

    //   en  s      clr | mis pv per flt err | mis1 err1
    add(1, 4'h0, 0,   0, 0, 0, 0, 0,   0, 0);  // IDLE -> PRIME
    add(1, 4'h2, 0,   0, 0, 0, 0, 0,   0, 0);  // primed, not compared
    add(1, 4'h0, 0,   0, 0, 0, 0, 0,   0, 0);  // first REF visit arms
    add(1, 4'h2, 0,   0, 0, 0, 0, 0,   0, 0);
    add(1, 4'h0, 0,   0, 1, 2, 0, 0,   0, 0);  // period = 2
    add(1, 4'h2, 0,   0, 0, 2, 0, 0,   0, 0);
    add(0, 4'h0, 0,   0, 0, 2, 0, 0,   0, 0);  // en gap -> IDLE
    add(1, 4'h0, 0,   0, 0, 2, 0, 0,   0, 0);  // IDLE -> PRIME
    add(1, 4'h3, 0,   0, 0, 2, 0, 0,   0, 0);  // prime with 0011
    add(1, 4'hd, 0,   0, 0, 2, 0, 0,   0, 0);  // legal 1101
    add(1, 4'hf, 0,   1, 0, 2, 1, 1,   1, 1);  // expected 1011 -> fault on u0
    add(1, 4'h0, 0,   0, 0, 2, 1, 1,   1, 2);  // u0 held in FAULT, u1 second bad
    add(1, 4'h0, 1,   0, 0, 2, 0, 0,   0, 0);  // clear beats coincident bad on u1
    add(1, 4'hf, 0,   0, 0, 2, 0, 0,   0, 0);  // PRIME: not compared
    add(1, 4'h1, 0,   0, 0, 2, 0, 0,   0, 0);  // legal after 1111

    do_reset();

    foreach (tbl[k]) begin
      step(tbl[k].en, tbl[k].s, tbl[k].clr);
      chk($sformatf("tbl%0d.mismatch", k), mis0, tbl[k].mis);
      chk($sformatf("tbl%0d.period_valid", k), pv0, tbl[k].pv);
      chk($sformatf("tbl%0d.period", k), per0, tbl[k].per);
      chk($sformatf("tbl%0d.fault", k), flt0, tbl[k].flt);
      chk($sformatf("tbl%0d.err_count", k), err0, tbl[k].err);
      chk($sformatf("tbl%0d.u1_mismatch", k), mis1, tbl[k].mis1);
      chk($sformatf("tbl%0d.u1_err_count", k), err1, tbl[k].err1);
    end

    // Five consecutive bad transitions on the 2-bit, never-fault instance.
    pulses = 0;
    repeat (5) begin
      step(1, 4'h0, 0);
      if (mis2) pulses++;
    end
    chk("sat.pulses", pulses, 5);
    chk("sat.err_count", err2, 3);
    chk("sat.fault", flt2, 0);
    chk("sat.u0_fault", flt0, 1);

    // Asynchronous reset mid-RUN with u1 holding two errors.
    do_reset();
    step(1, 4'h0, 0);
    step(1, 4'h0, 0);
    step(1, 4'h0, 0);
    step(1, 4'h0, 0);
    chk("async.pre_err_count", err1, 2);
    #3 reset = 1'b0;
    #1;
    chk("async.u1_err_count", err1, 0);
    chk("async.u1_mismatch", mis1, 0);
    chk("async.u0_fault", flt0, 0);
    chk("async.u0_err_count", err0, 0);
    chk("async.u2_err_count", err2, 0);
    chk("async.u0_period", per0, 0);
    chk("async.u1_hist", hist1, 0);
    do_reset();

    // Randomized traffic: mostly legal counter sequence with occasional corruption.
    cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      bit e;
      bit c;
      e = ($urandom_range(7) != 0);
      c = ($urandom_range(31) == 0);
      cnt = legal(cnt);
      if ($urandom_range(9) == 0) cnt = $urandom_range(15);
      step(e, 4'(cnt), c);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
